// File: rtl/gpt_slave_mode_ctrl.sv
// Slave-mode controller for the GPT: decides every cycle whether the counter counts, reloads, starts or stops.
// Trigger goes through an optional synchroniser and an edge detector. Every output is registered.
module gpt_slave_mode_ctrl #(
  parameter int SYNC_STAGES = 0
) (
  input  logic       aclk_i,
  input  logic       areset_i,
  input  logic [2:0] sms_i,
  input  logic       opm_i,
  input  logic       cen_i,
  input  logic       ug_i,
  input  logic       trgi_i,
  input  logic       uev_i,
  output logic       cnt_en_o,
  output logic       cnt_reset_o,
  output logic       cen_set_o,
  output logic       cen_clr_o,
  output logic       tif_o,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_STOP = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  logic       trg_sync;
  logic       trgi_q;
  logic       trg_rise;
  logic       mode_active;
  logic       mode_gated;
  logic       mode_edge_start;
  logic       mode_edge_reload;
  logic [1:0] state_q, state_d;
  logic       cnt_en_q, cnt_reset_q, cen_set_q, cen_clr_q, tif_q;
  logic       cnt_reset_d, cen_set_d, cen_clr_d, tif_d;

  // Sync flops reset high so a trigger held high across reset release is not seen as an edge.
  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge aclk_i or posedge areset_i) begin
        if (areset_i) begin
          sync_q <= '1;
        end else begin
          sync_q[0] <= trgi_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end
      assign trg_sync = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign trg_sync = trgi_i;
    end
  endgenerate

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) trgi_q <= 1'b1;
    else          trgi_q <= trg_sync;
  end

  assign trg_rise = trg_sync & ~trgi_q;

  // Codes 001..011 decode to "off", i.e. only 1xx codes are active modes.
  assign mode_active      = sms_i[2];
  assign mode_gated       = (sms_i == 3'b101);
  assign mode_edge_start  = (sms_i[2:1] == 2'b11);
  assign mode_edge_reload = (sms_i == 3'b100) || (sms_i == 3'b111);

  always_comb begin
    state_d     = state_q;
    cnt_reset_d = ug_i;
    cen_set_d   = 1'b0;
    cen_clr_d   = 1'b0;
    tif_d       = trg_rise & mode_active;
    case (state_q)
      ST_RUN: begin
        // CEN reads low for one cycle after cen_set_o while the CSR catches up.
        if (!cen_i && !cen_set_q) begin
          state_d = ST_STOP;
        end else begin
          if (opm_i && uev_i) begin
            state_d   = ST_STOP;
            cen_clr_d = 1'b1;
          end else if (mode_gated && !trg_sync) begin
            state_d = ST_HOLD;
          end
          if (mode_edge_reload && trg_rise) cnt_reset_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!mode_gated)   state_d = cen_i ? ST_RUN : ST_STOP;
        else if (!cen_i)   state_d = ST_STOP;
        else if (trg_sync) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_STOP;
        if (mode_edge_start) begin
          if (trg_rise) begin
            state_d   = ST_RUN;
            cen_set_d = 1'b1;
            if (sms_i[0]) cnt_reset_d = 1'b1;
          end
        end else if (cen_i) begin
          state_d = (mode_gated && !trg_sync) ? ST_HOLD : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q     <= ST_STOP;
      cnt_en_q    <= 1'b0;
      cnt_reset_q <= 1'b0;
      cen_set_q   <= 1'b0;
      cen_clr_q   <= 1'b0;
      tif_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_en_q    <= (state_d == ST_RUN);
      cnt_reset_q <= cnt_reset_d;
      cen_set_q   <= cen_set_d;
      cen_clr_q   <= cen_clr_d;
      tif_q       <= tif_d;
    end
  end

  assign cnt_en_o    = cnt_en_q;
  assign cnt_reset_o = cnt_reset_q;
  assign cen_set_o   = cen_set_q;
  assign cen_clr_o   = cen_clr_q;
  assign tif_o       = tif_q;
  assign state_o     = state_q;

endmodule
